// File: rtl/soc_system_fifo_clear_pkg.sv
// Shared definitions for the shared-FIFO clear controller:
// FSM state encoding, CSR word addresses and STATUS/CONTROL bit positions.
package soc_system_fifo_clear_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_COUNT   = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_OWNER   = 1;
  localparam int unsigned STAT_TIMEOUT = 2;
  localparam int unsigned STAT_PEND0   = 3;
  localparam int unsigned STAT_PEND1   = 4;

  localparam int unsigned CTRL_SWREQ   = 0;
  localparam int unsigned CTRL_CLR_TO  = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

endpackage

// File: rtl/soc_system_fifo_clear_arb.sv
// Two-requester clear arbiter: rising-edge detection of the Nios (0) and
// HPS (1) request levels, sticky pend latches and round-robin grant.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   req_nios, req_hps request levels from the PIOs
//   sw_req            software request, sets pend[0]
//   last_owner        requester served most recently
//   grant_en          consume the current grant (controller is idle)
//   pend              pending request latches
//   grant_valid       at least one request pending
//   grant_id          requester that would be granted now
module soc_system_fifo_clear_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_nios,
  input  logic       req_hps,
  input  logic       sw_req,
  input  logic       last_owner,
  input  logic       grant_en,
  output logic [1:0] pend,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] req;
  logic [1:0] req_q;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;

  assign req         = {req_hps, req_nios};
  assign set_mask    = (req & ~req_q) | {1'b0, sw_req};
  assign grant_valid = |pend;
  // On a tie the requester that did not go last wins.
  assign grant_id    = (&pend) ? ~last_owner : pend[1];

  always_comb begin
    clr_mask = '0;
    if (grant_en && grant_valid) clr_mask[grant_id] = 1'b1;
  end

  // A new request arriving on the grant edge survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= req;
      pend  <= set_mask | (pend & ~clr_mask);
    end
  end

endmodule

// File: rtl/soc_system_fifo_clear_ctrl.sv
// Clear sequencer for the FIFO shared by the Nios and the HPS. Grants a
// pending request, holds fifo_sclr for CLR_CYCLES, blocks producers until
// the FIFO reports empty (or TIMEOUT expires), then pulses clr_done.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata          Avalon-MM CSR slave (zero-wait read)
//   req_nios, req_hps            clear request levels
//   fifo_empty                   FIFO empty flag
//   fifo_sclr, fifo_wr_block     FIFO clear / producer inhibit
//   clr_done                     one-cycle completion pulse
//   irq                          timeout interrupt (level)
module soc_system_fifo_clear_ctrl
  import soc_system_fifo_clear_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        req_nios,
  input  logic        req_hps,
  input  logic        fifo_empty,
  output logic        fifo_sclr,
  output logic        fifo_wr_block,
  output logic        clr_done,
  output logic        irq
);

  localparam logic [7:0]  CNT_LOAD = 8'(CLR_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic [15:0]      timer;
  logic [CNT_W-1:0] done_count;
  logic             timeout_sticky;
  logic             irq_en;
  logic             last_owner;
  logic             wr;
  logic             sw_req;
  logic             tmo_hit;
  logic [1:0]       pend;
  logic             grant_valid;
  logic             grant_id;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign sw_req       = wr && (address == ADDR_CONTROL) && writedata[CTRL_SWREQ];
  assign tmo_hit      = (state == ST_WAIT) && !fifo_empty && (timer == TMO_LAST);
  assign irq          = timeout_sticky & irq_en;
  assign unused_wdata = ^writedata[31:3];

  soc_system_fifo_clear_arb u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_nios    (req_nios),
    .req_hps     (req_hps),
    .sw_req      (sw_req),
    .last_owner  (last_owner),
    .grant_en    (state == ST_IDLE),
    .pend        (pend),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    fifo_sclr     = 1'b0;
    fifo_wr_block = 1'b0;
    clr_done      = 1'b0;
    case (state)
      ST_IDLE:  if (grant_valid) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        fifo_sclr     = 1'b1;
        fifo_wr_block = 1'b1;
        if (cnt == '0) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        fifo_wr_block = 1'b1;
        if (fifo_empty || tmo_hit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        clr_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      timer          <= '0;
      done_count     <= '0;
      timeout_sticky <= 1'b0;
      irq_en         <= 1'b0;
      last_owner     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (grant_valid) begin
          cnt        <= CNT_LOAD;
          last_owner <= grant_id;
        end
        ST_CLEAR: begin
          if (cnt == '0) timer <= '0;
          else           cnt   <= cnt - 8'd1;
        end
        ST_WAIT: if (!fifo_empty && !tmo_hit) timer <= timer + 16'd1;
        default: ;
      endcase

      if (wr && address == ADDR_COUNT) done_count <= '0;
      else if (state == ST_DONE)       done_count <= done_count + 1'b1;

      if (tmo_hit)
        timeout_sticky <= 1'b1;
      else if (wr && address == ADDR_CONTROL && writedata[CTRL_CLR_TO])
        timeout_sticky <= 1'b0;

      if (wr && address == ADDR_CONTROL) irq_en <= writedata[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: begin
        readdata[STAT_BUSY]    = (state != ST_IDLE);
        readdata[STAT_OWNER]   = last_owner;
        readdata[STAT_TIMEOUT] = timeout_sticky;
        readdata[STAT_PEND0]   = pend[0];
        readdata[STAT_PEND1]   = pend[1];
      end
      ADDR_COUNT:   readdata[CNT_W-1:0]  = done_count;
      ADDR_CONTROL: readdata[CTRL_IRQ_EN] = irq_en;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_soc_system_fifo_clear_ctrl.sv
// Directed bench for the FIFO clear controller. Each requested clear pushes
// its expected owner and WAIT length; every clr_done pops and compares.
module tb_soc_system_fifo_clear_ctrl;

  localparam int unsigned CLR = 4;
  localparam int unsigned TMO = 8;

  typedef struct {
    logic        owner;
    int unsigned wait_len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        req_nios;
  logic        req_hps;
  logic        fifo_empty;
  logic        fifo_sclr;
  logic        fifo_wr_block;
  logic        clr_done;
  logic        irq;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic        prev_sclr  = 1'b0;
  logic        owner_obs  = 1'b0;
  int unsigned sclr_len   = 0;
  int unsigned wait_len   = 0;
  int unsigned sclr_rises = 0;

  soc_system_fifo_clear_ctrl #(.CLR_CYCLES(CLR), .TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .req_nios      (req_nios),
    .req_hps       (req_hps),
    .fifo_empty    (fifo_empty),
    .fifo_sclr     (fifo_sclr),
    .fifo_wr_block (fifo_wr_block),
    .clr_done      (clr_done),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_op(input logic o, input int unsigned w);
    exp_t e;
    e.owner    = o;
    e.wait_len = w;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and observe the clear sequence.
  task automatic step();
    exp_t        e;
    logic [1:0]  saved;
    @(negedge clk);
    if (fifo_sclr && !prev_sclr) begin
      sclr_rises++;
      sclr_len = 1;
      saved    = address;
      address  = 2'd0;
      #1;
      owner_obs = readdata[1];
      address   = saved;
    end else if (fifo_sclr) begin
      sclr_len++;
    end
    if (fifo_wr_block && !fifo_sclr) wait_len++;
    if (clr_done) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("owner", 32'(owner_obs), 32'(e.owner));
        chk("sclr_len", sclr_len, CLR);
        chk("wait_len", wait_len, e.wait_len);
      end
      wait_len = 0;
    end
    prev_sclr = fifo_sclr;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    address    = 2'd0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] d;
    address = a;
    #1;
    d       = readdata;
    address = 2'd0;
    chk(tag, d, e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || fifo_wr_block || clr_done) && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 200), 32'd1);
    step();
    step();
    chk({tag, "_settle"}, 32'(fifo_wr_block), 32'd0);
  endtask

  initial begin
    int          n;
    int unsigned rises_before;

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    req_nios   = 1'b0;
    req_hps    = 1'b0;
    fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclr", 32'(fifo_sclr), 32'd0);
    chk("rst_wrblk", 32'(fifo_wr_block), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    expect_reg("rst_status", 2'd0, 32'h2);
    expect_reg("rst_count", 2'd1, 32'h0);
    expect_reg("rst_control", 2'd2, 32'h0);
    reset_n = 1'b1;
    step();

    // Tie from reset: Nios first, then HPS back to back.
    req_nios = 1'b1;
    req_hps  = 1'b1;
    exp_op(1'b0, 1);
    exp_op(1'b1, 1);
    step();
    req_nios = 1'b0;
    req_hps  = 1'b0;
    drain("tie1");
    expect_reg("tie1_count", 2'd1, 32'd2);
    expect_reg("tie1_status", 2'd0, 32'h2);

    req_nios = 1'b1;
    req_hps  = 1'b1;
    exp_op(1'b0, 1);
    exp_op(1'b1, 1);
    step();
    req_nios = 1'b0;
    req_hps  = 1'b0;
    drain("tie2");
    expect_reg("tie2_count", 2'd1, 32'd4);

    // Single request: latency and exact sclr window.
    csr_write(2'd1, 32'hFFFF);
    expect_reg("count_cleared", 2'd1, 32'd0);
    req_nios = 1'b1;
    exp_op(1'b0, 1);
    step();
    chk("lat_idle_sclr", 32'(fifo_sclr), 32'd0);
    step();
    chk("lat_sclr", 32'(fifo_sclr), 32'd1);
    chk("lat_wrblk", 32'(fifo_wr_block), 32'd1);
    req_nios = 1'b0;
    drain("single");
    expect_reg("single_count", 2'd1, 32'd1);
    expect_reg("single_status", 2'd0, 32'h0);

    // Timeout with FIFO never empty.
    fifo_empty = 1'b0;
    req_hps    = 1'b1;
    exp_op(1'b1, TMO);
    step();
    req_hps = 1'b0;
    drain("timeout");
    fifo_empty = 1'b1;
    expect_reg("to_status", 2'd0, 32'h6);
    chk("to_irq_masked", 32'(irq), 32'd0);
    csr_write(2'd2, 32'h4);
    chk("to_irq_on", 32'(irq), 32'd1);
    expect_reg("to_control", 2'd2, 32'h4);
    csr_write(2'd2, 32'h6);
    chk("to_irq_cleared", 32'(irq), 32'd0);
    expect_reg("to_status_clr", 2'd0, 32'h2);
    expect_reg("to_control_kept", 2'd2, 32'h4);
    expect_reg("addr3", 2'd3, 32'h0);

    // Coalescing: three HPS rises during a Nios clear give one HPS clear.
    req_nios = 1'b1;
    exp_op(1'b0, 1);
    exp_op(1'b1, 1);
    step();
    req_nios = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      req_hps = 1'b1;
      step();
      req_hps = 1'b0;
      step();
    end
    drain("coalesce");
    exp_op(1'b0, 1);
    csr_write(2'd2, 32'h1);
    drain("swreq");

    // Software request landing on the grant edge of requester 0.
    req_nios = 1'b1;
    exp_op(1'b0, 1);
    exp_op(1'b0, 1);
    step();
    req_nios = 1'b0;
    csr_write(2'd2, 32'h1);
    drain("sw_at_grant");

    // COUNT write in the DONE cycle wins.
    req_nios = 1'b1;
    exp_op(1'b0, 1);
    step();
    req_nios = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!clr_done && n < 50);
    chk("collision_reach", 32'(clr_done), 32'd1);
    csr_write(2'd1, 32'h0);
    expect_reg("collision_count", 2'd1, 32'd0);
    drain("collision");

    // Reset in CLEAR with a second request pending.
    req_nios = 1'b1;
    exp_op(1'b0, 1);
    step();
    req_hps = 1'b1;
    step();
    chk("pre_rst_sclr", 32'(fifo_sclr), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_sclr", 32'(fifo_sclr), 32'd0);
    chk("async_wrblk", 32'(fifo_wr_block), 32'd0);
    chk("async_done", 32'(clr_done), 32'd0);
    sb.delete();
    prev_sclr = 1'b0;
    sclr_len  = 0;
    wait_len  = 0;
    req_nios  = 1'b0;
    req_hps   = 1'b0;
    step();
    step();
    reset_n      = 1'b1;
    rises_before = sclr_rises;
    repeat (10) step();
    chk("post_rst_no_clear", sclr_rises - rises_before, 32'd0);
    expect_reg("post_rst_status", 2'd0, 32'h2);
    expect_reg("post_rst_count", 2'd1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_system_fifo_clear_ctrl.md
# soc_system_fifo_clear_ctrl

Sequences flush operations for a Qsys FIFO that is shared by the Nios and the HPS. The block edge-detects clear requests from the two 1-bit PIO outputs, plus a software request written over Avalon-MM. It arbitrates between them round-robin and drives a timed synchronous clear to the FIFO. During the operation it blocks producers and waits for the FIFO to report empty, then reports completion and timeouts through a 4-word CSR slave.

## Interface
- CLR_CYCLES, 4: number of cycles `fifo_sclr` is held high; legal range 1..255.
- TIMEOUT, 1023: maximum number of WAIT cycles before the operation is abandoned; legal range 1..65535.
- CNT_W, 16: width of the completed-clear counter; legal range 1..32.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  CSR word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux; zero-wait-state read.
- req_nios  in  1  level request from the Nios clear PIO (requester 0).
- req_hps  in  1  level request from the HPS clear PIO (requester 1).
- fifo_empty  in  1  FIFO empty flag.
- fifo_sclr  out  1  synchronous clear to the FIFO.
- fifo_wr_block  out  1  write inhibit to the FIFO producers.
- clr_done  out  1  one-cycle completion pulse.
- irq  out  1  level interrupt, equal to `timeout_sticky & irq_en`.

## Operation
Register map (a write is `chipselect & ~write_n`):
- Address 0, STATUS (read-only):
  - [0] busy (state != IDLE)
  - [1] last_owner
  - [2] timeout_sticky
  - [3] pend0
  - [4] pend1
- Address 1, COUNT: a read returns the completed clears in [CNT_W-1:0]. A write of any value clears the counter.
- Address 2, CONTROL:
  - Write: bit0=1 sets pend0 (software request); bit1=1 clears timeout_sticky; bit2 is stored as irq_en.
  - Read: irq_en in [2]; all other bits read 0.
- Address 3 reads 0. Unused bits read 0.

Request capture:
- `req_x_q` registers each request input.
- A rise (`req_x & ~req_x_q`) sets `pend_x`.
- A rise while `pend_x` is already set is coalesced into the existing request.
- A rise during the requester's own active operation sets `pend_x` again, which produces a second clear.

FSM states (IDLE, CLEAR, WAIT, DONE):
- IDLE: if any pend bit is set, grant a requester.
  - When both are pending, the winner is the requester that is not `last_owner`.
  - On grant: clear the winner's pend bit, set `last_owner` to the winner, load `cnt = CLR_CYCLES-1`, go to CLEAR.
- CLEAR: decrement `cnt`; when `cnt == 0`, go to WAIT and reset `timer` to 0.
- WAIT:
  - If `fifo_empty`, go to DONE.
  - Otherwise, if `timer == TIMEOUT-1`, set timeout_sticky and go to DONE.
  - Otherwise, increment `timer`.
- DONE: increment COUNT (wraps at 2^CNT_W), go to IDLE.

Outputs are Moore decodes of the state register:
- `fifo_sclr` is high in CLEAR.
- `fifo_wr_block` is high in CLEAR and WAIT.
- `clr_done` is high in DONE.

Simultaneous events:
- A COUNT write in the same cycle as a DONE increment: the write wins and COUNT becomes 0.
- A timeout set in the same cycle as a bit1 clear: the set wins.
- A software pend0 set in the same cycle as the grant of requester 0: pend0 stays set.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - pend bits, `req_x_q`, COUNT, timeout_sticky and irq_en all 0.
  - `last_owner` = 1, so requester 0 wins the first tie.
- A request level that is already high when reset is released produces one clear, because `req_x_q` resets to 0.
- Latency: a rise sampled at edge N sets pend at N. IDLE grants at edge N+1. `fifo_sclr` is high from N+1 for exactly CLR_CYCLES cycles.
- Operation duration:
  - WAIT lasts at least 1 cycle.
  - The minimum IDLE-to-IDLE time is CLR_CYCLES+2 cycles of non-IDLE state.
  - On timeout, WAIT lasts exactly TIMEOUT cycles.
- Reset asserted mid-operation: `fifo_sclr`, `fifo_wr_block` and `clr_done` drop asynchronously, and pending requests are discarded.
- `readdata` is valid in the same cycle as `address`.

## Structure
- Shared package `soc_system_fifo_clear_pkg` holds:
  - the state encoding (2 bits)
  - the CSR word addresses
  - the STATUS and CONTROL bit indices
- Sub-module `soc_system_fifo_clear_arb` implements the 2-requester edge detection, the pend latches and the round-robin grant (inputs: `last_owner`, `grant_en`).
- The FSM, counters and CSR logic live in the top module.

## Test plan
- Single request, CLR_CYCLES=4: pulse `req_nios` high with `fifo_empty`=1 → `fifo_sclr` high for exactly 4 cycles, WAIT lasts 1 cycle, `clr_done` pulses once, COUNT=1, STATUS[1]=0.
- Tie: raise `req_nios` and `req_hps` in the same cycle → the Nios clear is served first, then the HPS clear back-to-back; COUNT=2 and `last_owner`=1. Repeat the tie → the HPS is not served first again and the order is Nios, HPS.
- Timeout, TIMEOUT=8: hold `fifo_empty`=0 → WAIT lasts 8 cycles, then STATUS[2]=1, and `irq`=1 once irq_en is set. Write 0x2 to address 2 → `irq` falls.
- Coalescing: toggle `req_hps` three times during a Nios clear → exactly one HPS clear follows. Write 0x1 to address 2 → an additional requester-0 clear follows.
- Collision: write address 1 in the DONE cycle → COUNT reads 0.
- Reset mid-operation: assert `reset_n` low in CLEAR → `fifo_sclr`=0 immediately; after release the block stays IDLE with no pending bits set.
